ldm_stm_seq: RTL and testbench

Load/store-multiple register sequencer for the ARM9 execute/memory path. Accepts an LDM/STM 16-bit register list and the P/U addressing bits, then steps through the set registers lowest-first, one per accepted memory cycle. For each step it emits the register number, its one-hot register-file select (built with the 4→16 `decode` block), the word address, and finally the base writeback value. It is the only block that sequences multi-register transfers to the register file ports.

---
 rtl/ldm_stm_seq.sv | 154 +++++++++++++++
 tb/tb_ldm_stm_seq.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ldm_stm_seq.sv
// LDM/STM register sequencer: walks a 16-bit register list lowest-first and
// presents one register/address pair per accepted memory cycle.

module decode (
    input  logic [3:0]  i_sel,
    output logic [15:0] o_dec
);
    assign o_dec = 16'h0001 << i_sel;
endmodule

module ldm_stm_seq (
    input  logic        nGCLK,
    input  logic        nRESET,
    input  logic        start,
    input  logic [15:0] reg_list,
    input  logic        pre,
    input  logic        up,
    input  logic [31:0] base,
    input  logic        stall,
    input  logic        abort,
    output logic        busy,
    output logic        xfer,
    output logic [3:0]  reg_num,
    output logic [15:0] reg_sel,
    output logic [31:0] addr,
    output logic        last,
    output logic        done,
    output logic [31:0] wb_addr
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [15:0] r_list, w_list_nxt;
    logic [31:0] r_addr, w_addr_nxt;
    logic [31:0] r_wb_addr, w_wb_addr_nxt;

    logic [4:0]  w_n;
    logic [31:0] w_n4;
    logic [31:0] w_start_addr;
    logic [3:0]  w_lowest;
    logic [15:0] w_dec;
    logic        w_one_left;
    logic        w_xfer;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] cnt;
        cnt = 5'd0;
        for (int i = 0; i < 16; i++) begin
            cnt = cnt + {4'd0, v[i]};
        end
        return cnt;
    endfunction

    assign w_n  = popcount16(reg_list);
    assign w_n4 = {25'd0, w_n, 2'b00};

    // Every mode lays the block out ascending; only the lowest address moves.
    always_comb begin
        unique case ({pre, up})
            2'b01:   w_start_addr = base;
            2'b11:   w_start_addr = base + 32'd4;
            2'b00:   w_start_addr = base - w_n4 + 32'd4;
            default: w_start_addr = base - w_n4;
        endcase
    end

    // Scanning downward lets the lowest set bit overwrite any higher one.
    always_comb begin
        w_lowest = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (r_list[i]) begin
                w_lowest = 4'(i);
            end
        end
    end

    decode u_decode (
        .i_sel (w_lowest),
        .o_dec (w_dec)
    );

    assign w_one_left = (r_list != 16'd0) && ((r_list & (r_list - 16'd1)) == 16'd0);
    assign w_xfer     = (r_state == S_XFER);

    always_comb begin
        // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
        w_state_nxt   = r_state;
        w_list_nxt    = r_list;
        w_addr_nxt    = r_addr;
        w_wb_addr_nxt = r_wb_addr;

        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_list_nxt    = reg_list;
                    w_addr_nxt    = w_start_addr;
                    w_wb_addr_nxt = up ? (base + w_n4) : (base - w_n4);
                    w_state_nxt   = (w_n != 5'd0) ? S_XFER : S_DONE;
                end
            end
            S_XFER: begin
                if (!stall) begin
                    w_list_nxt = r_list & ~w_dec;
                    w_addr_nxt = r_addr + 32'd4;
                    if (w_one_left) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Abort discards the remaining list and suppresses the done pulse.
        if (abort) begin
            w_state_nxt = S_IDLE;
            w_list_nxt  = 16'd0;
        end
    end

    // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
    always_ff @(posedge nGCLK or negedge nRESET) begin
        if (!nRESET) begin
            r_state   <= S_IDLE;
            r_list    <= 16'd0;
            r_addr    <= 32'd0;
            r_wb_addr <= 32'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_list    <= w_list_nxt;
            r_addr    <= w_addr_nxt;
            r_wb_addr <= w_wb_addr_nxt;
        end
    end

    assign busy    = (r_state != S_IDLE);
    assign xfer    = w_xfer;
    assign done    = (r_state == S_DONE);
    assign reg_num = w_xfer ? w_lowest : 4'd0;
    assign reg_sel = w_xfer ? w_dec : 16'h0000;
    assign last    = w_xfer & w_one_left;
    assign addr    = r_addr;
    assign wb_addr = r_wb_addr;

endmodule

// File: tb/tb_ldm_stm_seq.sv
// Bench for ldm_stm_seq: table of addressing-mode vectors checked through a
// transfer scoreboard, plus abort and mid-sequence reset sequences.

module tb_ldm_stm_seq;

    logic        nGCLK;
    logic        nRESET;
    logic        start;
    logic [15:0] reg_list;
    logic        pre;
    logic        up;
    logic [31:0] base;
    logic        stall;
    logic        abort;
    logic        busy;
    logic        xfer;
    logic [3:0]  reg_num;
    logic [15:0] reg_sel;
    logic [31:0] addr;
    logic        last;
    logic        done;
    logic [31:0] wb_addr;

    ldm_stm_seq dut (
        .nGCLK    (nGCLK),
        .nRESET   (nRESET),
        .start    (start),
        .reg_list (reg_list),
        .pre      (pre),
        .up       (up),
        .base     (base),
        .stall    (stall),
        .abort    (abort),
        .busy     (busy),
        .xfer     (xfer),
        .reg_num  (reg_num),
        .reg_sel  (reg_sel),
        .addr     (addr),
        .last     (last),
        .done     (done),
        .wb_addr  (wb_addr)
    );

    initial nGCLK = 1'b0;
    always #5 nGCLK = ~nGCLK;

    typedef struct {
        logic [15:0] list;
        logic        pre;
        logic        up;
        logic [31:0] base;
        logic [31:0] exp_first;
        logic [31:0] exp_wb;
        int          exp_n;
        int          stall_at;
        int          stall_len;
        bit          hold_start;
    } vec_t;

    typedef struct packed {
        logic [3:0]  rn;
        logic [31:0] addr;
        logic        last;
    } xfer_t;

    xfer_t sb[$];
    vec_t  vecs[9];
    int    n_vec = 0;
    int    n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},    32'(busy),    32'd0);
        check({tag, "_xfer"},    32'(xfer),    32'd0);
        check({tag, "_reg_num"}, 32'(reg_num), 32'd0);
        check({tag, "_reg_sel"}, 32'(reg_sel), 32'd0);
        check({tag, "_addr"},    addr,         32'd0);
        check({tag, "_last"},    32'(last),    32'd0);
        check({tag, "_done"},    32'(done),    32'd0);
        check({tag, "_wb_addr"}, wb_addr,      32'd0);
    endtask

    // Called at #1 after a rising edge with the DUT idle; start is sampled at the next edge.
    task automatic run_vec(input vec_t v);
        int    k;
        int    stalls;
        int    idx;
        bit    seen;
        xfer_t e;
        k      = 0;
        stalls = 0;
        seen   = 1'b0;
        sb.delete();
        for (int i = 0; i < 16; i++) begin
            if (v.list[i]) begin
                e.rn   = 4'(i);
                e.addr = v.exp_first + 32'(4 * k);
                e.last = (k == v.exp_n - 1);
                sb.push_back(e);
                k++;
            end
        end
        start    = 1'b1;
        reg_list = v.list;
        pre      = v.pre;
        up       = v.up;
        base     = v.base;
        stall    = 1'b0;
        for (int c = 1; c <= 60 && !seen; c++) begin
            @(posedge nGCLK);
            #1;
            if (c == 1) begin
                check("wb_addr", wb_addr, v.exp_wb);
                start    = v.hold_start;
                reg_list = 16'h5A5A;
                base     = 32'hDEAD0000;
                pre      = ~v.pre;
                up       = ~v.up;
            end
            stall = 1'b0;
            if (done) begin
                seen  = 1'b1;
                start = 1'b0;
                check("done_cycle", 32'(c), 32'(v.exp_n + stalls + 1));
                check("sb_empty", 32'(sb.size()), 32'd0);
                check("done_xfer", 32'(xfer), 32'd0);
            end else if (xfer) begin
                if (sb.size() == 0) begin
                    check("xfer_unexpected", 32'(xfer), 32'd0);
                end else begin
                    e   = sb[0];
                    idx = v.exp_n - sb.size();
                    check("reg_num", 32'(reg_num), 32'(e.rn));
                    check("addr",    addr,         e.addr);
                    check("last",    32'(last),    32'(e.last));
                    check("reg_sel", 32'(reg_sel), 32'(16'h0001 << e.rn));
                    check("busy",    32'(busy),    32'd1);
                    if (idx == v.stall_at && stalls < v.stall_len) begin
                        stall = 1'b1;
                        stalls++;
                    end else begin
                        void'(sb.pop_front());
                    end
                end
            end else begin
                check("xfer_expected", 32'(xfer), 32'd1);
            end
        end
        check("done_seen", 32'(seen), 32'd1);
        start = 1'b0;
        stall = 1'b0;
        @(posedge nGCLK);
        #1;
        check("done_pulse_end", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        //           list      P     U     base          first         wb            n   stall_at len hold
        vecs[0] = '{16'h8001, 1'b0, 1'b1, 32'h00001000, 32'h00001000, 32'h00001008, 2,  -1, 0, 1'b0};
        vecs[1] = '{16'h00F0, 1'b1, 1'b0, 32'h00002000, 32'h00001FF0, 32'h00001FF0, 4,  -1, 0, 1'b1};
        vecs[2] = '{16'h00F0, 1'b0, 1'b0, 32'h00002000, 32'h00001FF4, 32'h00001FF0, 4,  -1, 0, 1'b0};
        vecs[3] = '{16'h00F0, 1'b1, 1'b1, 32'h00002000, 32'h00002004, 32'h00002010, 4,  -1, 0, 1'b0};
        vecs[4] = '{16'h0007, 1'b0, 1'b1, 32'h00000100, 32'h00000100, 32'h0000010C, 3,   1, 2, 1'b0};
        vecs[5] = '{16'h0000, 1'b0, 1'b1, 32'h00003000, 32'h00000000, 32'h00003000, 0,  -1, 0, 1'b1};
        vecs[6] = '{16'hFFFF, 1'b1, 1'b1, 32'hFFFFFFF8, 32'hFFFFFFFC, 32'h00000038, 16, 15, 1, 1'b0};
        vecs[7] = '{16'h8000, 1'b0, 1'b0, 32'h00000000, 32'h00000000, 32'hFFFFFFFC, 1,  -1, 0, 1'b1};
        vecs[8] = '{16'h0000, 1'b1, 1'b0, 32'h00005000, 32'h00000000, 32'h00005000, 0,  -1, 0, 1'b0};

        nRESET   = 1'b0;
        start    = 1'b0;
        reg_list = 16'h0;
        pre      = 1'b0;
        up       = 1'b0;
        base     = 32'h0;
        stall    = 1'b0;
        abort    = 1'b0;
        #12;
        check_all_zero("reset");
        nRESET = 1'b1;
        @(posedge nGCLK);
        #1;

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i]);
        end

        // Abort with stall asserted during the 2nd of 4 transfers.
        start    = 1'b1;
        reg_list = 16'h000F;
        pre      = 1'b0;
        up       = 1'b1;
        base     = 32'h00000400;
        @(posedge nGCLK);
        #1;
        start = 1'b0;
        check("ab_rn0",   32'(reg_num), 32'd0);
        check("ab_addr0", addr,         32'h00000400);
        @(posedge nGCLK);
        #1;
        check("ab_rn1",   32'(reg_num), 32'd1);
        check("ab_addr1", addr,         32'h00000404);
        abort = 1'b1;
        stall = 1'b1;
        @(posedge nGCLK);
        #1;
        abort = 1'b0;
        stall = 1'b0;
        check("ab_busy",    32'(busy),    32'd0);
        check("ab_xfer",    32'(xfer),    32'd0);
        check("ab_done",    32'(done),    32'd0);
        check("ab_reg_sel", 32'(reg_sel), 32'd0);
        @(posedge nGCLK);
        #1;
        check("ab_done_later", 32'(done), 32'd0);
        check("ab_idle",       32'(busy), 32'd0);
        run_vec(vecs[0]);

        // Asynchronous reset in the middle of a sequence.
        start    = 1'b1;
        reg_list = 16'h00FF;
        pre      = 1'b0;
        up       = 1'b1;
        base     = 32'h00008000;
        @(posedge nGCLK);
        #1;
        start = 1'b0;
        @(posedge nGCLK);
        #1;
        check("rst_pre_busy", 32'(busy), 32'd1);
        #3;
        nRESET = 1'b0;
        #1;
        check_all_zero("midrst");
        #2;
        nRESET = 1'b1;
        @(posedge nGCLK);
        #1;
        check("rst_post_busy", 32'(busy), 32'd0);
        run_vec(vecs[3]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
